bcd_lap_timer: RTL and testbench

BCD_LAP_TIMER -- requirements
Module: bcd_lap_timer

---
 rtl/bcd_lap_timer.sv | 136 +++++++++++++
 tb/tb_bcd_lap_timer.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_lap_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// bcd_lap_timer : prescaled multi-digit BCD up/down counter with lap freeze
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module bcd_lap_timer #(
  parameter int CLK_FREQ = 100000000,
  parameter int TICK_HZ  = 1,
  parameter int DIGITS   = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  run,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   time_reading,
  output logic                  lap_active,
  output logic                  tick,
  output logic                  wrap,
  output logic                  expired
);

  localparam int W          = 4 * DIGITS;
  localparam int DIV        = CLK_FREQ / TICK_HZ;
  localparam int PW         = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  logic [PW-1:0] presc_q, presc_d;
  logic [W-1:0]  count_q, count_d;
  logic [W-1:0]  lap_q, lap_d;
  logic          lap_active_q, lap_active_d;
  logic          tick_q, tick_d;
  logic          wrap_q, wrap_d;
  logic          expired_q, expired_d;

  logic [W-1:0]  count_inc, count_dec, load_sat;
  logic          inc_carry, dec_borrow;
  logic          step;

  // Ripple carry/borrow across digits; a decrement from all-0s is pinned at zero.
  always_comb begin
    count_inc  = '0;
    count_dec  = '0;
    load_sat   = '0;
    inc_carry  = 1'b1;
    dec_borrow = (count_q != '0);
    for (int i = 0; i < DIGITS; i++) begin
      count_inc[4*i +: 4] = inc_carry ?
          ((count_q[4*i +: 4] == 4'd9) ? 4'd0 : count_q[4*i +: 4] + 4'd1) :
          count_q[4*i +: 4];
      inc_carry = inc_carry && (count_q[4*i +: 4] == 4'd9);
      count_dec[4*i +: 4] = dec_borrow ?
          ((count_q[4*i +: 4] == 4'd0) ? 4'd9 : count_q[4*i +: 4] - 4'd1) :
          count_q[4*i +: 4];
      dec_borrow = dec_borrow && (count_q[4*i +: 4] == 4'd0);
      load_sat[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  assign step = run && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d      = presc_q;
    count_d      = count_q;
    lap_d        = lap_q;
    lap_active_d = lap_active_q;
    tick_d       = 1'b0;
    wrap_d       = 1'b0;
    expired_d    = expired_q;
    if (clear) begin
      presc_d      = '0;
      count_d      = '0;
      lap_d        = '0;
      lap_active_d = 1'b0;
      expired_d    = 1'b0;
    end else begin
      if (load) begin
        count_d   = load_sat;
        presc_d   = '0;
        expired_d = 1'b0;
      end else if (run) begin
        presc_d = step ? '0 : presc_q + PW'(1);
        if (step) begin
          tick_d = 1'b1;
          if (down) begin
            count_d = count_dec;
            if (count_dec == '0) expired_d = 1'b1;
          end else begin
            count_d = count_inc;
            wrap_d  = inc_carry;
          end
        end
      end
      // Lap captures the pre-edge count, so a coincident step is not reflected.
      if (lap) begin
        if (lap_active_q) begin
          lap_active_d = 1'b0;
        end else begin
          lap_d        = count_q;
          lap_active_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q      <= '0;
      count_q      <= '0;
      lap_q        <= '0;
      lap_active_q <= 1'b0;
      tick_q       <= 1'b0;
      wrap_q       <= 1'b0;
      expired_q    <= 1'b0;
    end else begin
      presc_q      <= presc_d;
      count_q      <= count_d;
      lap_q        <= lap_d;
      lap_active_q <= lap_active_d;
      tick_q       <= tick_d;
      wrap_q       <= wrap_d;
      expired_q    <= expired_d;
    end
  end

  assign time_reading = lap_active_q ? lap_q : count_q;
  assign lap_active   = lap_active_q;
  assign tick         = tick_q;
  assign wrap         = wrap_q;
  assign expired      = expired_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_lap_timer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_bcd_lap_timer : directed scoreboard bench for bcd_lap_timer (DIV = 10)
// Revision 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_bcd_lap_timer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clear, run, down, load, lap;
  logic [7:0] load_val;
  logic [7:0] time_reading;
  logic       lap_active, tick, wrap, expired;

  bcd_lap_timer #(.CLK_FREQ(10), .TICK_HZ(1), .DIGITS(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .run          (run),
    .down         (down),
    .load         (load),
    .load_val     (load_val),
    .lap          (lap),
    .time_reading (time_reading),
    .lap_active   (lap_active),
    .tick         (tick),
    .wrap         (wrap),
    .expired      (expired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         c;
    logic [7:0] tr;
    logic       la;
    logic       wr;
    logic       ex;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic push(input int c, input logic [7:0] tr, input logic la,
                      input logic wr, input logic ex);
    exp_t e;
    e.c = c; e.tr = tr; e.la = la; e.wr = wr; e.ex = ex;
    exp_q.push_back(e);
  endtask

  // Every tick is the DUT presenting a step result; it must match the next expectation.
  always @(negedge clk) begin
    if (rst_n && tick) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_tick cyc=%0d got tr=%h la=%b wr=%b ex=%b",
                 cyc, time_reading, lap_active, wrap, expired);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (cyc != e.c || time_reading !== e.tr || lap_active !== e.la ||
            wrap !== e.wr || expired !== e.ex) begin
          n_bad++;
          $display("FAIL tick_result got cyc=%0d tr=%h la=%b wr=%b ex=%b want cyc=%0d tr=%h la=%b wr=%b ex=%b",
                   cyc, time_reading, lap_active, wrap, expired, e.c, e.tr, e.la, e.wr, e.ex);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s got=%h want=%h", name, act, want);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int base;

  initial begin
    rst_n = 1'b0; clear = 1'b0; run = 1'b0; down = 1'b0;
    load = 1'b0; lap = 1'b0; load_val = 8'h00;
    step(2);
    check("reset_tr",  32'(time_reading), 32'h00);
    check("reset_la",  32'(lap_active),   32'h0);
    check("reset_ex",  32'(expired),      32'h0);
    rst_n = 1'b1;

    // Free-running up count: a tick every 10 cycles, ten of them.
    base = cyc;
    run  = 1'b1;
    for (int k = 1; k <= 10; k++)
      push(base + 10*k, 8'((k/10)*16 + (k%10)), 1'b0, 1'b0, 1'b0);
    step(100);
    check("up100_tr", 32'(time_reading), 32'h10);
    run = 1'b0;

    // Up wrap from 99.
    load = 1'b1; load_val = 8'h99;
    step(1);
    load = 1'b0; run = 1'b1; base = cyc;
    push(base + 10, 8'h00, 1'b0, 1'b1, 1'b0);
    step(10);
    check("wrap_tr",  32'(time_reading), 32'h00);
    check("wrap_hi",  32'(wrap),         32'h1);
    check("wrap_ex",  32'(expired),      32'h0);
    step(1);
    check("wrap_lo",  32'(wrap),         32'h0);
    run = 1'b0;

    // Down count to zero, then hold at zero with expired sticky.
    load = 1'b1; load_val = 8'h03;
    step(1);
    load = 1'b0; run = 1'b1; down = 1'b1; base = cyc;
    push(base + 10, 8'h02, 1'b0, 1'b0, 1'b0);
    push(base + 20, 8'h01, 1'b0, 1'b0, 1'b0);
    push(base + 30, 8'h00, 1'b0, 1'b0, 1'b1);
    step(30);
    check("down_tr", 32'(time_reading), 32'h00);
    check("down_ex", 32'(expired),      32'h1);
    push(base + 40, 8'h00, 1'b0, 1'b0, 1'b1);
    push(base + 50, 8'h00, 1'b0, 1'b0, 1'b1);
    step(20);
    check("zero_hold_tr", 32'(time_reading), 32'h00);
    check("zero_hold_ex", 32'(expired),      32'h1);
    run = 1'b0; load = 1'b1; load_val = 8'h42;
    step(1);
    check("load_clr_ex", 32'(expired),      32'h0);
    check("load_tr",     32'(time_reading), 32'h42);
    load_val = 8'hA7;
    step(1);
    check("load_sat", 32'(time_reading), 32'h97);
    load = 1'b0; down = 1'b0;

    // Lap freeze at 05 while the count keeps running.
    load = 1'b1; load_val = 8'h00;
    step(1);
    load = 1'b0; run = 1'b1; base = cyc;
    for (int k = 1; k <= 5; k++) push(base + 10*k, 8'(k), 1'b0, 1'b0, 1'b0);
    step(50);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("lap_tr", 32'(time_reading), 32'h05);
    check("lap_la", 32'(lap_active),   32'h1);
    for (int k = 6; k <= 8; k++) push(base + 10*k, 8'h05, 1'b1, 1'b0, 1'b0);
    step(30);
    check("lap30_tr", 32'(time_reading), 32'h05);
    check("lap30_la", 32'(lap_active),   32'h1);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("unlap_tr", 32'(time_reading), 32'h08);
    check("unlap_la", 32'(lap_active),   32'h0);

    // Run held low with prescaler at 7; resume gives a step three edges later.
    push(base + 90, 8'h09, 1'b0, 1'b0, 1'b0);
    step(15);
    run = 1'b0;
    step(50);
    check("hold_tr", 32'(time_reading), 32'h09);
    run = 1'b1; base = cyc;
    push(base + 3, 8'h10, 1'b0, 1'b0, 1'b0);
    step(3);
    check("resume_tr", 32'(time_reading), 32'h10);

    // Clear beats load, and a lap in the same cycle is ignored.
    clear = 1'b1; load = 1'b1; load_val = 8'h55; lap = 1'b1;
    step(1);
    clear = 1'b0; load = 1'b0; lap = 1'b0; run = 1'b0;
    check("clear_tr",   32'(time_reading), 32'h00);
    check("clear_la",   32'(lap_active),   32'h0);
    check("clear_tick", 32'(tick),         32'h0);

    // Lap capture coinciding with a step keeps the pre-step value.
    load = 1'b1; load_val = 8'h20;
    step(1);
    load = 1'b0; run = 1'b1; base = cyc;
    step(9);
    lap = 1'b1;
    push(base + 10, 8'h20, 1'b1, 1'b0, 1'b0);
    step(1);
    lap = 1'b0; run = 1'b0;
    check("lapstep_tr", 32'(time_reading), 32'h20);
    check("lapstep_la", 32'(lap_active),   32'h1);
    lap = 1'b1;
    step(1);
    lap = 1'b0;
    check("lapstep_rel", 32'(time_reading), 32'h21);

    // Asynchronous reset mid-interval with the display frozen.
    lap = 1'b1;
    step(1);
    lap = 1'b0; run = 1'b1;
    step(4);
    #3 rst_n = 1'b0;
    #1;
    check("areset_tr",   32'(time_reading), 32'h00);
    check("areset_la",   32'(lap_active),   32'h0);
    check("areset_tick", 32'(tick),         32'h0);
    check("areset_wrap", 32'(wrap),         32'h0);
    check("areset_ex",   32'(expired),      32'h0);
    step(1);
    run = 1'b0; rst_n = 1'b1;
    step(2);

    check("pending_ticks", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
